tone_sequencer: RTL
===================

Name: tone_sequencer

Overview:
- Plays a fixed melody on the PMOD AMP speaker pin by sequencing a square-wave tone generator through a note table.
- Each table entry gives a half-period (in clocks) and a duration (in ms ticks). Notes are separated by a silent gap.
- Sits between board I/O (switches, LEDs, jd[] PMOD header) and the speaker/shutdown pins.
- Supersedes the free-running single-beep path.

Parameters:
- TICK_DIV, 100000, clocks per duration tick (1 ms at 100 MHz); must be >= 2.
- GAP_TICKS, 20, silent ticks inserted after every note; 0 means no gap.
- NUM_NOTES, 16, note-table depth; power of two, at most 16.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request to begin playback from entry 0.
- stop  in  1  abort playback; level or pulse.
- loop_en  in  1  when 1, restart at entry 0 after end of song.
- amp_en_sw  in  1  user amplifier enable (sw[3]).
- speaker_out  out  1  PMOD AMP audio input (jd[0]).
- amp_sd_n  out  1  PMOD AMP shutdown_n (jd[3]).
- busy  out  1  high in every state except IDLE.
- note_idx  out  4  index of the current table entry.
- done  out  1  1-cycle pulse at end of song.

Behaviour:
- Reset: state = IDLE; all outputs 0; note_idx = 0; tone, tick and duration counters = 0. Clock is CLK100MHZ; reset is synchronous, active-high.
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - start = 1 and stop = 0 -> LOAD; note_idx = 0.
  - start while busy is ignored.
- LOAD (1 cycle): read entry[note_idx] = {half_period[17:0], dur[9:0]}.
  - dur == 0 -> DONE.
  - otherwise -> PLAY. On entry to PLAY the tone counter and tick counter clear, dur_cnt = dur, and the square output sq = 0.
- PLAY:
  - Tone counter counts 0..half_period-1. At terminal count it wraps to 0 and sq toggles, so the square period is 2*half_period clocks.
  - half_period == 0 means a rest: sq is held 0 while the duration still counts.
  - The tick counter pulses every TICK_DIV clocks; each pulse decrements dur_cnt.
  - On the tick that takes dur_cnt to 0: sq = 0, then go to GAP, or to ADVANCE if GAP_TICKS == 0.
- GAP: sq = 0 for GAP_TICKS ticks, then advance.
- Advance:
  - note_idx == NUM_NOTES-1 -> DONE. The index never wraps silently.
  - otherwise note_idx + 1, then LOAD.
- DONE (1 cycle): done = 1.
  - loop_en = 1 -> LOAD with note_idx = 0.
  - loop_en = 0 -> IDLE with note_idx = 0.
- Stop:
  - stop = 1 in any non-IDLE state -> IDLE on the next edge.
  - sq, speaker_out and amp_sd_n are 0 from that edge; done is not pulsed.
  - stop and start in the same cycle: stop wins, remain IDLE.
- Outputs:
  - amp_sd_n = amp_en_sw & busy, registered, 1-cycle latency.
  - speaker_out is registered.
  - Start-to-first-tone latency: start at cycle N -> LOAD at N+1 -> PLAY at N+2. The first sq edge occurs half_period clocks into PLAY.
- Width rules: all counters are unsigned; the tone counter is 18 bits, dur_cnt 10 bits, and the tick counter ceil(log2(TICK_DIV)) bits. No counter overflows within the parameter ranges above.

Optional Feature:
- Macro: MUSIC_ATTEN_EN.
- Defined: speaker_out = sq & (atten_cnt == 0), where atten_cnt is a free-running 7-bit counter that is reset to 0. This gives 1/128 volume.
- Undefined: speaker_out = sq at full volume, and atten_cnt is not instantiated.

Decomposition:
- music_pkg holds:
  - the note_t struct {half_period[17:0], dur[9:0]};
  - the state_t enum;
  - the NOTE_ROM constant array (default melody: C4..C5 scale, half_period = 100e6/(2*f), end marker dur = 0);
  - the HP_W/DUR_W widths.
- One sub-module, tone_gen:
  - inputs: clear, enable, half_period;
  - output: sq;
  - owns the tone counter.
- The FSM, tick divider and attenuation stay in tone_sequencer.

Test Plan:
- Tone and duration. TICK_DIV=10, GAP_TICKS=2, ROM {hp=5,dur=3},{dur=0}; start pulse -> busy=1 next cycle. sq toggles every 5 clocks for 30 clocks, then 20 clocks of silence, then done pulses once, then busy=0, note_idx=0.
- Rest. Entry {hp=0,dur=4} -> speaker_out stays 0 for 40 clocks while note_idx holds 0, then advances to 1.
- Stop mid-note. Assert stop 7 clocks into PLAY -> next edge: busy=0, speaker_out=0, amp_sd_n=0, no done pulse. A start 3 cycles later replays from entry 0.
- Simultaneous and ignored starts. start and stop in the same cycle from IDLE -> remains IDLE. A start during PLAY -> no restart; note_idx unchanged.
- Looping and the table-full boundary. loop_en=1 with all 16 entries non-zero -> after entry 15, DONE pulses, then LOAD with note_idx=0. amp_sd_n follows amp_en_sw during busy.
- Attenuation. With MUSIC_ATTEN_EN: speaker_out is high only when atten_cnt=0, at most 1 clock in 128. Without it: speaker_out equals sq. Reset asserted mid-PLAY -> every output is 0 on the next edge.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types, widths and the default note table for the tone sequencer.
// Each table entry packs {half_period, dur}; dur == 0 marks end of song.
package music_pkg;

  localparam int unsigned HP_W      = 18;
  localparam int unsigned DUR_W     = 10;
  localparam int unsigned ROM_DEPTH = 16;

  typedef struct packed {
    logic [HP_W-1:0]  half_period;
    logic [DUR_W-1:0] dur;
  } note_t;

  typedef note_t [ROM_DEPTH-1:0] note_rom_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

  function automatic note_t mk_note(input int unsigned hp, input int unsigned dur);
    note_t n;
    n.half_period = HP_W'(hp);
    n.dur         = DUR_W'(dur);
    return n;
  endfunction

  // C4..C5 major scale, 250 ms per note, half_period = 100e6 / (2 * f)
  function automatic note_rom_t default_rom();
    note_rom_t rom;
    rom    = '0;
    rom[0] = mk_note(191113, 250);
    rom[1] = mk_note(170265, 250);
    rom[2] = mk_note(151685, 250);
    rom[3] = mk_note(143172, 250);
    rom[4] = mk_note(127551, 250);
    rom[5] = mk_note(113636, 250);
    rom[6] = mk_note(101239, 250);
    rom[7] = mk_note(95557, 250);
    return rom;
  endfunction

  localparam note_rom_t NOTE_ROM = default_rom();

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles sq every half_period enabled clocks.
// half_period == 0 is a rest and holds sq low.
module tone_gen
  import music_pkg::*;
(
  input  logic            CLK100MHZ,
  input  logic            clear,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            sq
);

  logic [HP_W-1:0] tone_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (clear) begin
      tone_cnt <= '0;
      sq       <= 1'b0;
    end else if (enable) begin
      if (half_period == '0) begin
        tone_cnt <= '0;
        sq       <= 1'b0;
      end else if (tone_cnt == half_period - 1'b1) begin
        tone_cnt <= '0;
        sq       <= ~sq;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Steps tone_gen through a note table with a silent gap after each note.
// Define MUSIC_ATTEN_EN to gate the speaker output down to 1/128 duty.
module tone_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned NUM_NOTES  = 16,
  parameter note_rom_t   NOTE_TABLE = NOTE_ROM
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       amp_en_sw,
  output logic       speaker_out,
  output logic       amp_sd_n,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int unsigned     TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_TICKS);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_NOTES - 1);

  state_t            state, state_next;
  logic [3:0]        idx_next;
  logic [DUR_W-1:0]  dur_cnt, dur_next;
  logic [TICK_W-1:0] tick_cnt;
  logic              timed, tick, adv, sq, spk_gate, tg_clear;
  note_t             cur_note;

  assign cur_note = NOTE_TABLE[note_idx];
  assign timed    = (state == PLAY) || (state == GAP);
  assign tick     = timed && (tick_cnt == TICK_LAST);

  // dur_cnt counts note ticks in PLAY and is reloaded with the gap length for GAP
  always_comb begin
    state_next = state;
    idx_next   = note_idx;
    dur_next   = dur_cnt;
    adv        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        if (cur_note.dur == '0) begin
          state_next = DONE;
        end else begin
          state_next = PLAY;
          dur_next   = cur_note.dur;
        end
      end
      PLAY: begin
        if (tick) begin
          dur_next = dur_cnt - 1'b1;
          if (dur_cnt == DUR_W'(1)) begin
            if (GAP_TICKS == 0) begin
              adv = 1'b1;
            end else begin
              state_next = GAP;
              dur_next   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          dur_next = dur_cnt - 1'b1;
          if (dur_cnt == DUR_W'(1)) adv = 1'b1;
        end
      end
      DONE: begin
        idx_next   = '0;
        state_next = loop_en ? LOAD : IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    if (adv) begin
      if (note_idx == LAST_IDX) begin
        state_next = DONE;
      end else begin
        state_next = LOAD;
        idx_next   = note_idx + 1'b1;
      end
    end
    if (state != IDLE && stop) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state    <= IDLE;
      note_idx <= '0;
      dur_cnt  <= '0;
    end else begin
      state    <= state_next;
      note_idx <= idx_next;
      dur_cnt  <= dur_next;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset || !timed || state_next != state) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tg_clear = reset || (state != PLAY) || (state_next != PLAY);

  tone_gen u_tone (
    .CLK100MHZ  (CLK100MHZ),
    .clear      (tg_clear),
    .enable     (state == PLAY),
    .half_period(cur_note.half_period),
    .sq         (sq)
  );

`ifdef MUSIC_ATTEN_EN
  logic [6:0] atten_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) atten_cnt <= '0;
    else       atten_cnt <= atten_cnt + 1'b1;
  end

  assign spk_gate = (atten_cnt == '0);
`else
  assign spk_gate = 1'b1;
`endif

  // Registered from next-state so stop/reset silence the pins on the same edge
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      speaker_out <= 1'b0;
      amp_sd_n    <= 1'b0;
    end else begin
      speaker_out <= sq && spk_gate && (state_next == PLAY);
      amp_sd_n    <= amp_en_sw && (state_next != IDLE);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
